// File: rtl/gpio_link_protocol.sv
// Full-duplex nibble link for the two-board battleship connection: 16-bit messages
// travel as four MSB-first nibbles, each under a four-phase req/ack handshake.
module gpio_link_protocol #(
   parameter int SETUP_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] tx_data,
   input  logic        tx_start,
   output logic        tx_busy,
   output logic        tx_done,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   output logic        timeout_error,
   output logic [5:0]  link_out,
   input  logic [5:0]  link_in
);

   localparam int CMAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_SETUP, TX_REQ_HI, TX_REQ_LO, TX_DONE} tx_state_t;
   typedef enum logic {RX_IDLE, RX_ACK_HI} rx_state_t;

   tx_state_t     tx_state, tx_next;
   rx_state_t     rx_state, rx_next;
   logic [1:0]    req_pipe, ack_pipe;
   logic          req_sync, ack_sync;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic [15:0]   tx_shift, rx_asm;
   logic [1:0]    tx_idx;
   logic [2:0]    rx_count;
   logic          tx_abort, rx_resync, rx_capture, rx_release;
   logic          tx_req, rx_ack;

   assign req_sync = req_pipe[1];
   assign ack_sync = ack_pipe[1];

   // Only the handshake strobes are synchronised; the nibble is sampled once req is stable.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_pipe <= 2'b00;
         ack_pipe <= 2'b00;
      end else begin
         req_pipe <= {req_pipe[0], link_in[4]};
         ack_pipe <= {ack_pipe[0], link_in[5]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) tx_state <= TX_IDLE;
      else       tx_state <= tx_next;
   end

   always_comb begin
      tx_next  = tx_state;
      tx_abort = 1'b0;
      case (tx_state)
         TX_IDLE:   if (tx_start) tx_next = TX_SETUP;
         TX_SETUP:  if (tx_cnt == SETUP_LAST) tx_next = TX_REQ_HI;
         TX_REQ_HI: begin
            if (ack_sync) tx_next = TX_REQ_LO;
            else if (tx_cnt == TIMEOUT_LAST) begin
               tx_next  = TX_IDLE;
               tx_abort = 1'b1;
            end
         end
         TX_REQ_LO: begin
            if (!ack_sync) tx_next = (tx_idx == 2'd3) ? TX_DONE : TX_SETUP;
            else if (tx_cnt == TIMEOUT_LAST) begin
               tx_next  = TX_IDLE;
               tx_abort = 1'b1;
            end
         end
         TX_DONE:   tx_next = TX_IDLE;
         default:   tx_next = TX_IDLE;
      endcase
   end

   // The wait counter restarts on every state change, so one counter times setup and both waits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_cnt   <= '0;
         tx_shift <= 16'h0000;
         tx_idx   <= 2'd0;
      end else begin
         if (tx_next != tx_state || tx_state == TX_IDLE) tx_cnt <= '0;
         else                                             tx_cnt <= tx_cnt + 1'b1;
         if (tx_state == TX_IDLE && tx_start) begin
            tx_shift <= tx_data;
            tx_idx   <= 2'd0;
         end else if (tx_state == TX_REQ_LO && tx_next == TX_SETUP) begin
            tx_shift <= {tx_shift[11:0], 4'h0};
            tx_idx   <= tx_idx + 2'd1;
         end
      end
   end

   always_comb begin
      tx_req  = (tx_state == TX_REQ_HI);
      tx_busy = (tx_state != TX_IDLE);
      tx_done = (tx_state == TX_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;
   end

   always_comb begin
      rx_next    = rx_state;
      rx_resync  = 1'b0;
      rx_capture = 1'b0;
      rx_release = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (req_sync) begin
               rx_next    = RX_ACK_HI;
               rx_capture = 1'b1;
            end else if (rx_count != 3'd0 && rx_cnt == TIMEOUT_LAST) begin
               rx_resync = 1'b1;
            end
         end
         RX_ACK_HI: begin
            if (!req_sync) begin
               rx_next    = RX_IDLE;
               rx_release = 1'b1;
            end else if (rx_cnt == TIMEOUT_LAST) begin
               rx_next   = RX_IDLE;
               rx_resync = 1'b1;
            end
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   // An idle receiver with no partial message has nothing to time out, so its counter rests at zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_cnt   <= '0;
         rx_asm   <= 16'h0000;
         rx_count <= 3'd0;
         rx_data  <= 16'h0000;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (rx_next != rx_state || rx_resync || (rx_state == RX_IDLE && rx_count == 3'd0))
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         if (rx_capture) begin
            rx_asm   <= {rx_asm[11:0], link_in[3:0]};
            rx_count <= rx_count + 3'd1;
         end else if (rx_resync) begin
            rx_count <= 3'd0;
         end else if (rx_release && rx_count == 3'd4) begin
            rx_data  <= rx_asm;
            rx_valid <= 1'b1;
            rx_count <= 3'd0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) timeout_error <= 1'b0;
      else       timeout_error <= tx_abort | rx_resync;
   end

   always_comb begin
      rx_ack   = (rx_state == RX_ACK_HI);
      link_out = {rx_ack, tx_req, tx_shift[15:12]};
   end

endmodule

// File: tb/tb_gpio_link_protocol.sv
// Directed bench for gpio_link_protocol: loopback message table plus hand-written
// timeout, resync, busy-retrigger and mid-transfer reset sequences.
module tb_gpio_link_protocol;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] tx_data;
   logic        tx_start;
   logic        tx_busy, tx_done, rx_valid, timeout_error;
   logic [15:0] rx_data;
   logic [5:0]  link_out, link_in, peer_in;
   logic        loopback;

   int tests_run = 0;
   int tests_failed = 0;

   logic [3:0]  nib_log[$];
   int          done_total = 0;
   int          valid_total = 0;
   int          to_total = 0;
   logic [15:0] last_rx = 16'h0000;
   logic        req_prev = 1'b0;

   typedef struct {
      logic [15:0] data;
      logic [15:0] exp_rx;
      logic [3:0]  n0, n1, n2, n3;
   } vec_t;

   vec_t vecs[5];

   always #5 clock = ~clock;

   assign link_in = loopback ? link_out : peer_in;

   gpio_link_protocol #(.SETUP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock),
      .reset(reset),
      .tx_data(tx_data),
      .tx_start(tx_start),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .timeout_error(timeout_error),
      .link_out(link_out),
      .link_in(link_in)
   );

   // Observes pulses and the nibble presented at each req rise.
   always @(negedge clock) begin
      if (link_out[4] && !req_prev) nib_log.push_back(link_out[3:0]);
      req_prev = link_out[4];
      if (tx_done) done_total++;
      if (rx_valid) begin
         valid_total++;
         last_rx = rx_data;
      end
      if (timeout_error) to_total++;
   end

   task automatic tick();
      @(negedge clock);
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] data);
      tx_data  = data;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
   endtask

   task automatic runLoopback(input logic [15:0] data, input logic [15:0] exp_rx,
                              input logic [3:0] n0, input logic [3:0] n1,
                              input logic [3:0] n2, input logic [3:0] n3);
      int d0, v0, nb, budget;
      logic [3:0] exp_n[4];
      exp_n[0] = n0; exp_n[1] = n1; exp_n[2] = n2; exp_n[3] = n3;
      d0 = done_total; v0 = valid_total; nb = nib_log.size();
      applyStimulus(data);
      budget = 0;
      while (!(done_total > d0 && valid_total > v0) && budget < 300) begin
         tick();
         budget++;
      end
      checkOutput("loopback completes", budget < 300, 1);
      tick();
      tick();
      checkOutput("one tx_done", done_total - d0, 1);
      checkOutput("one rx_valid", valid_total - v0, 1);
      checkOutput("rx_data at valid", last_rx, exp_rx);
      checkOutput("rx_data held", rx_data, exp_rx);
      checkOutput("tx_busy after done", tx_busy, 0);
      checkOutput("nibble count", nib_log.size() - nb, 4);
      for (int i = 0; i < 4; i++)
         if (nb + i < nib_log.size()) checkOutput("nibble order", nib_log[nb + i], exp_n[i]);
   endtask

   task automatic peerNibble(input logic [3:0] n);
      int b;
      peer_in[3:0] = n;
      tick();
      tick();
      peer_in[4] = 1'b1;
      b = 0;
      while (!link_out[5] && b < 20) begin tick(); b++; end
      checkOutput("peer ack rise", link_out[5], 1);
      peer_in[4] = 1'b0;
      b = 0;
      while (link_out[5] && b < 20) begin tick(); b++; end
      checkOutput("peer ack fall", link_out[5], 0);
   endtask

   initial begin
      int d0, v0, t0, nb, budget, early;
      vecs[0] = '{16'hA53C, 16'hA53C, 4'hA, 4'h5, 4'h3, 4'hC};
      vecs[1] = '{16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 4'hF, 4'hF};
      vecs[3] = '{16'hC0DE, 16'hC0DE, 4'hC, 4'h0, 4'hD, 4'hE};
      vecs[4] = '{16'h8001, 16'h8001, 4'h8, 4'h0, 4'h0, 4'h1};

      reset = 1'b1; tx_data = 16'h0000; tx_start = 1'b0;
      peer_in = 6'b0; loopback = 1'b1;
      tick();
      tick();
      checkOutput("reset link_out", link_out, 0);
      checkOutput("reset rx_data", rx_data, 0);
      checkOutput("reset tx_busy", tx_busy, 0);
      checkOutput("reset strobes", {tx_done, rx_valid, timeout_error}, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++)
         runLoopback(vecs[i].data, vecs[i].exp_rx, vecs[i].n0, vecs[i].n1, vecs[i].n2, vecs[i].n3);

      // Retrigger while busy, then tx_start during DONE.
      d0 = done_total; v0 = valid_total; nb = nib_log.size();
      applyStimulus(16'h0F0F);
      tick();
      checkOutput("busy before retrig", tx_busy, 1);
      applyStimulus(16'hFFFF);
      budget = 0;
      while (!tx_done && budget < 300) begin tick(); budget++; end
      checkOutput("retrig reaches done", tx_done, 1);
      tx_data = 16'h1111;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      checkOutput("start in DONE ignored", tx_busy, 0);
      tick();
      tick();
      checkOutput("still idle", tx_busy, 0);
      checkOutput("retrig one tx_done", done_total - d0, 1);
      checkOutput("retrig one rx_valid", valid_total - v0, 1);
      checkOutput("retrig rx_data", last_rx, 16'h0F0F);
      checkOutput("retrig nibble count", nib_log.size() - nb, 4);
      if (nib_log.size() - nb >= 4) begin
         checkOutput("retrig nib0", nib_log[nb], 4'h0);
         checkOutput("retrig nib1", nib_log[nb + 1], 4'hF);
         checkOutput("retrig nib2", nib_log[nb + 2], 4'h0);
         checkOutput("retrig nib3", nib_log[nb + 3], 4'hF);
      end

      // Peer never acknowledges.
      loopback = 1'b0;
      peer_in = 6'b0;
      tick();
      d0 = done_total;
      applyStimulus(16'h1234);
      budget = 0;
      while (!link_out[4] && budget < 20) begin tick(); budget++; end
      checkOutput("req rises", link_out[4], 1);
      early = 0;
      for (int i = 1; i < 16; i++) begin
         tick();
         if (timeout_error || !link_out[4]) early++;
      end
      checkOutput("no early abort", early, 0);
      tick();
      checkOutput("timeout pulse", timeout_error, 1);
      checkOutput("req dropped", link_out[4], 0);
      checkOutput("busy cleared on abort", tx_busy, 0);
      tick();
      checkOutput("timeout one cycle", timeout_error, 0);
      checkOutput("no tx_done on abort", done_total - d0, 0);

      // Partial receive then resync, followed by a clean message.
      tick();
      tick();
      v0 = valid_total; t0 = to_total;
      peerNibble(4'h7);
      peerNibble(4'h1);
      budget = 0;
      while (to_total == t0 && budget < 40) begin tick(); budget++; end
      checkOutput("rx resync pulse", to_total - t0, 1);
      checkOutput("no valid on partial", valid_total - v0, 0);
      tick();
      tick();
      peerNibble(4'h1);
      peerNibble(4'h2);
      peerNibble(4'h3);
      peerNibble(4'h4);
      tick();
      tick();
      checkOutput("clean message valid", valid_total - v0, 1);
      checkOutput("clean message data", last_rx, 16'h1234);
      checkOutput("clean rx_data held", rx_data, 16'h1234);

      // Reset while req is high.
      loopback = 1'b1;
      peer_in = 6'b0;
      tick();
      v0 = valid_total;
      applyStimulus(16'h1357);
      budget = 0;
      while (!link_out[4] && budget < 30) begin tick(); budget++; end
      checkOutput("req high before reset", link_out[4], 1);
      reset = 1'b1;
      #1;
      checkOutput("async link clear", link_out, 0);
      checkOutput("async busy clear", tx_busy, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      checkOutput("no partial delivery", valid_total - v0, 0);
      checkOutput("rx_data cleared by reset", rx_data, 0);
      runLoopback(16'hBEEF, 16'hBEEF, 4'hB, 4'hE, 4'hE, 4'hF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
